// File: rtl/mlp_layer_sequencer_if.sv
// Handshake/bus bundle between the MLP layer sequencer and the 2-neuron datapath:
// host start, neuron strobes, input/weight/output-register BRAM ports.
interface mlp_layer_sequencer_if #(
  parameter int ADDR_W     = 14,
  parameter int REG_ADDR_W = 10,
  parameter int DATA_W     = 16
);
  logic                  pi_start;
  logic                  po_busy;
  logic                  po_done;
  logic                  po_clc_accumulator;
  logic                  po_valid;
  logic                  po_accumulation_done;
  logic                  po_ena_inp, po_enb_inp, po_wea_inp, po_web_inp;
  logic [ADDR_W-1:0]     po_addra_inp, po_addrb_inp;
  logic [DATA_W-1:0]     po_dia_inp, po_dib_inp;
  logic                  po_ena_wei, po_enb_wei;
  logic [ADDR_W-1:0]     po_addra_wei, po_addrb_wei;
  logic                  po_ena_reg, po_enb_reg, po_wea_reg, po_web_reg;
  logic [REG_ADDR_W-1:0] po_addra_reg, po_addrb_reg;
  logic [DATA_W-1:0]     pi_reg_doa;

  modport master (
    input  pi_start, pi_reg_doa,
    output po_busy, po_done, po_clc_accumulator, po_valid, po_accumulation_done,
           po_ena_inp, po_enb_inp, po_wea_inp, po_web_inp, po_addra_inp, po_addrb_inp,
           po_dia_inp, po_dib_inp, po_ena_wei, po_enb_wei, po_addra_wei, po_addrb_wei,
           po_ena_reg, po_enb_reg, po_wea_reg, po_web_reg, po_addra_reg, po_addrb_reg
  );

  modport slave (
    output pi_start, pi_reg_doa,
    input  po_busy, po_done, po_clc_accumulator, po_valid, po_accumulation_done,
           po_ena_inp, po_enb_inp, po_wea_inp, po_web_inp, po_addra_inp, po_addrb_inp,
           po_dia_inp, po_dib_inp, po_ena_wei, po_enb_wei, po_addra_wei, po_addrb_wei,
           po_ena_reg, po_enb_reg, po_wea_reg, po_web_reg, po_addra_reg, po_addrb_reg
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// 3-layer MLP forward-pass sequencer for the 2-neuron datapath, with output-register copy-back.
// Optional MLP_SEQ_PERF_CNT_EN adds po_cycle_cnt (busy-cycle counter of the last/current pass).
module mlp_layer_sequencer #(
  parameter int N_IN       = 784,
  parameter int N_H1       = 16,
  parameter int N_H2       = 16,
  parameter int N_OUT      = 10,
  parameter int ADDR_W     = 14,
  parameter int REG_ADDR_W = 10,
  parameter int DATA_W     = 16
) (
  input  logic pi_clk,
  input  logic pi_rst_n,
  mlp_layer_sequencer_if.master bus
`ifdef MLP_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] po_cycle_cnt
`endif
);
  localparam int TOT   = N_IN + N_H1 + N_H2 + N_OUT;
  localparam int N_WEI = N_IN*N_H1 + N_H1*N_H2 + N_H2*N_OUT;

  if (2*TOT > (1 << ADDR_W)) begin : g_inp_range
    $error("input BRAM too small for node buffer plus port-B mirror");
  end
  if (N_WEI > (1 << ADDR_W)) begin : g_wei_range
    $error("weight BRAM too small for all layer weights");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_MAC_ADDR, S_MAC_VALID, S_ACC0, S_ACC1, S_REG_WR,
    S_COPY_RD, S_WAIT0, S_WAIT1, S_COPY_WR, S_DONE
  } state_t;

  state_t            state, nxt;
  logic [1:0]        lyr;
  logic [31:0]       j_cnt, k_cnt, m_base, n_base, p_ptr, cnt;
  logic [DATA_W-1:0] cap;
  logic [31:0]       prev, cur, wa;
  logic              last_k, more_j, more_cnt, busy;

  always_comb begin
    case (lyr)
      2'd0:    begin prev = 32'(N_IN); cur = 32'(N_H1);  end
      2'd1:    begin prev = 32'(N_H1); cur = 32'(N_H2);  end
      default: begin prev = 32'(N_H2); cur = 32'(N_OUT); end
    endcase
  end

  assign last_k   = (k_cnt == prev - 32'd1);
  assign more_j   = (j_cnt < (cur >> 1) - 32'd1);
  assign more_cnt = (cnt < n_base + cur - 32'd1);
  // neuron A weight row for pair j; neuron B's row follows it directly
  assign wa       = m_base + ((prev * j_cnt) << 1) + k_cnt;

  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) state <= S_IDLE;
    else           state <= nxt;
  end

  always_comb begin
    nxt                      = state;
    busy                     = (state != S_IDLE) && (state != S_DONE);
    bus.po_done              = 1'b0;
    bus.po_clc_accumulator   = 1'b0;
    bus.po_valid             = 1'b0;
    bus.po_accumulation_done = 1'b0;
    bus.po_ena_inp           = 1'b0;
    bus.po_enb_inp           = 1'b0;
    bus.po_wea_inp           = 1'b0;
    bus.po_web_inp           = 1'b0;
    bus.po_addra_inp         = '0;
    bus.po_addrb_inp         = '0;
    bus.po_dia_inp           = '0;
    bus.po_dib_inp           = '0;
    bus.po_ena_wei           = 1'b0;
    bus.po_enb_wei           = 1'b0;
    bus.po_addra_wei         = '0;
    bus.po_addrb_wei         = '0;
    bus.po_ena_reg           = 1'b0;
    bus.po_enb_reg           = 1'b0;
    bus.po_wea_reg           = 1'b0;
    bus.po_web_reg           = 1'b0;
    bus.po_addra_reg         = '0;
    bus.po_addrb_reg         = '0;
    case (state)
      S_IDLE: if (bus.pi_start) nxt = S_CLEAR;
      S_CLEAR: begin
        bus.po_clc_accumulator = 1'b1;
        nxt = S_MAC_ADDR;
      end
      S_MAC_ADDR: begin
        bus.po_ena_inp   = 1'b1;
        bus.po_enb_inp   = 1'b1;
        bus.po_addra_inp = ADDR_W'(n_base + k_cnt);
        bus.po_addrb_inp = ADDR_W'(n_base + k_cnt);
        bus.po_ena_wei   = 1'b1;
        bus.po_enb_wei   = 1'b1;
        bus.po_addra_wei = ADDR_W'(wa);
        bus.po_addrb_wei = ADDR_W'(wa + prev);
        bus.po_wea_reg   = 1'b1;
        bus.po_web_reg   = 1'b1;
        bus.po_addra_reg = REG_ADDR_W'(p_ptr);
        bus.po_addrb_reg = REG_ADDR_W'(p_ptr + 32'd1);
        nxt = S_MAC_VALID;
      end
      S_MAC_VALID: begin
        bus.po_valid = 1'b1;
        nxt = last_k ? S_ACC0 : S_MAC_ADDR;
      end
      S_ACC0: begin
        bus.po_accumulation_done = 1'b1;
        nxt = S_ACC1;
      end
      S_ACC1: begin
        bus.po_accumulation_done = 1'b1;
        nxt = S_REG_WR;
      end
      S_REG_WR: begin
        bus.po_ena_reg   = 1'b1;
        bus.po_enb_reg   = 1'b1;
        bus.po_wea_reg   = 1'b1;
        bus.po_web_reg   = 1'b1;
        bus.po_addra_reg = REG_ADDR_W'(p_ptr);
        bus.po_addrb_reg = REG_ADDR_W'(p_ptr + 32'd1);
        nxt = more_j ? S_CLEAR : S_COPY_RD;
      end
      S_COPY_RD, S_WAIT0, S_WAIT1: begin
        // read held across both wait cycles to cover the 2-cycle BRAM latency
        bus.po_ena_reg   = 1'b1;
        bus.po_addra_reg = REG_ADDR_W'(cnt);
        nxt = (state == S_COPY_RD) ? S_WAIT0 : (state == S_WAIT0) ? S_WAIT1 : S_COPY_WR;
      end
      S_COPY_WR: begin
        bus.po_ena_inp   = 1'b1;
        bus.po_enb_inp   = 1'b1;
        bus.po_wea_inp   = 1'b1;
        bus.po_web_inp   = 1'b1;
        bus.po_addra_inp = ADDR_W'(cnt);
        bus.po_addrb_inp = ADDR_W'(cnt + 32'(TOT));
        bus.po_dia_inp   = cap;
        bus.po_dib_inp   = cap;
        if (more_cnt)          nxt = S_COPY_RD;
        else if (lyr != 2'd2)  nxt = S_CLEAR;
        else                   nxt = S_DONE;
      end
      S_DONE: begin
        bus.po_done = 1'b1;
        nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign bus.po_busy = busy;

  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n) begin
      lyr    <= '0;
      j_cnt  <= '0;
      k_cnt  <= '0;
      m_base <= '0;
      n_base <= '0;
      p_ptr  <= '0;
      cnt    <= '0;
      cap    <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.pi_start) begin
          lyr    <= '0;
          j_cnt  <= '0;
          m_base <= '0;
          n_base <= '0;
          p_ptr  <= 32'(N_IN);
        end
        S_CLEAR:     k_cnt <= '0;
        S_MAC_VALID: if (!last_k) k_cnt <= k_cnt + 32'd1;
        S_REG_WR: begin
          p_ptr <= p_ptr + 32'd2;
          if (more_j) j_cnt <= j_cnt + 32'd1;
          else begin
            m_base <= m_base + prev * cur;
            n_base <= n_base + prev;
            cnt    <= n_base + prev;
          end
        end
        S_WAIT1: cap <= bus.pi_reg_doa;
        S_COPY_WR: begin
          if (more_cnt) cnt <= cnt + 32'd1;
          else if (lyr != 2'd2) begin
            lyr   <= lyr + 2'd1;
            j_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MLP_SEQ_PERF_CNT_EN
  always_ff @(posedge pi_clk or negedge pi_rst_n) begin
    if (!pi_rst_n)                          po_cycle_cnt <= '0;
    else if (state == S_IDLE && bus.pi_start) po_cycle_cnt <= '0;
    else if (busy)                          po_cycle_cnt <= po_cycle_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Randomized bench for mlp_layer_sequencer: transaction-level expectation queues built
// from the layer/pair/node loop structure, plus an output-register BRAM model.
module tb_mlp_layer_sequencer;
  localparam int NI = 4, NH1 = 2, NH2 = 2, NO = 2;
  localparam int AW = 14, RAW = 10, DW = 16;
  localparam int TOT = NI + NH1 + NH2 + NO;

  logic pi_clk, pi_rst_n;
  logic fixed_mode;
  logic [31:0] cycle_cnt;

  mlp_layer_sequencer_if #(.ADDR_W(AW), .REG_ADDR_W(RAW), .DATA_W(DW)) bif ();

  mlp_layer_sequencer #(
    .N_IN(NI), .N_H1(NH1), .N_H2(NH2), .N_OUT(NO),
    .ADDR_W(AW), .REG_ADDR_W(RAW), .DATA_W(DW)
  ) dut (
    .pi_clk(pi_clk),
    .pi_rst_n(pi_rst_n),
    .bus(bif)
`ifdef MLP_SEQ_PERF_CNT_EN
    ,
    .po_cycle_cnt(cycle_cnt)
`endif
  );
`ifndef MLP_SEQ_PERF_CNT_EN
  assign cycle_cnt = '0;
`endif

  initial pi_clk = 1'b0;
  always #5 pi_clk = ~pi_clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { int inp; int wa; int wb; int ra; } mac_t;
  mac_t mac_q[$];
  int   wr_q[$];
  int   cp_q[$];
  int   exp_busy, exp_valid;
  int   busy_cnt, done_cnt, valid_cnt;
  logic busy_prev;

  // expectations straight from the layer loop: pairs of neurons, then node copy-back
  task automatic build_model();
    int prv[3], cr[3];
    int m, n, p;
    prv = '{NI, NH1, NH2};
    cr  = '{NH1, NH2, NO};
    mac_q.delete(); wr_q.delete(); cp_q.delete();
    m = 0; n = 0; p = NI; exp_busy = 0; exp_valid = 0;
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j < cr[l]/2; j++) begin
        for (int k = 0; k < prv[l]; k++)
          mac_q.push_back('{n + k, m + 2*prv[l]*j + k, m + 2*prv[l]*j + k + prv[l], p});
        wr_q.push_back(p);
        p += 2;
        exp_busy  += 4 + 2*prv[l];
        exp_valid += prv[l];
      end
      m += prv[l]*cr[l];
      n += prv[l];
      for (int c = 0; c < cr[l]; c++) cp_q.push_back(n + c);
      exp_busy += 4*cr[l];
    end
    busy_cnt = 0; done_cnt = 0; valid_cnt = 0;
  endtask

  // output-register BRAM: datapath writes random results, reads have 2-cycle latency
  logic [DW-1:0] regmem [0:(1<<RAW)-1];
  logic [DW-1:0] q1, q2;
  always @(posedge pi_clk) begin
    if (bif.po_ena_reg && bif.po_wea_reg) regmem[bif.po_addra_reg] <= DW'($urandom);
    if (bif.po_enb_reg && bif.po_web_reg) regmem[bif.po_addrb_reg] <= DW'($urandom);
    if (bif.po_ena_reg) q1 <= regmem[bif.po_addra_reg];
    q2 <= q1;
  end
  assign bif.pi_reg_doa = fixed_mode ? 16'hA5A5 : q2;

  always @(negedge pi_clk) begin
    mac_t e;
    int c;
    logic [DW-1:0] d;
    if (pi_rst_n) begin
      if (bif.po_busy)  busy_cnt++;
      if (bif.po_valid) valid_cnt++;
      if (bif.po_done) begin
        done_cnt++;
        chk("done_after_busy", 32'(busy_prev), 32'd1);
        chk("busy_at_done", 32'(bif.po_busy), 32'd0);
      end
      if (bif.po_ena_wei) begin
        chk("mac_expected", 32'(mac_q.size() > 0), 32'd1);
        if (mac_q.size() > 0) begin
          e = mac_q.pop_front();
          chk("mac_inp_a", 32'(bif.po_addra_inp), 32'(e.inp));
          chk("mac_inp_b", 32'(bif.po_addrb_inp), 32'(e.inp));
          chk("mac_wei_a", 32'(bif.po_addra_wei), 32'(e.wa));
          chk("mac_wei_b", 32'(bif.po_addrb_wei), 32'(e.wb));
          chk("mac_reg_a", 32'(bif.po_addra_reg), 32'(e.ra));
          chk("mac_reg_b", 32'(bif.po_addrb_reg), 32'(e.ra + 1));
          chk("mac_ctl", 32'({bif.po_enb_wei, bif.po_ena_inp, bif.po_enb_inp,
                              bif.po_wea_inp, bif.po_ena_reg, bif.po_wea_reg}), 32'b111001);
        end
      end
      if (bif.po_ena_reg && bif.po_enb_reg) begin
        chk("regwr_expected", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) begin
          c = wr_q.pop_front();
          chk("regwr_a", 32'(bif.po_addra_reg), 32'(c));
          chk("regwr_b", 32'(bif.po_addrb_reg), 32'(c + 1));
          chk("regwr_we", 32'({bif.po_wea_reg, bif.po_web_reg}), 32'b11);
        end
      end
      if (bif.po_ena_reg && !bif.po_enb_reg) begin
        chk("cprd_expected", 32'(cp_q.size() > 0), 32'd1);
        if (cp_q.size() > 0) begin
          chk("cprd_addr", 32'(bif.po_addra_reg), 32'(cp_q[0]));
          chk("cprd_we", 32'(bif.po_wea_reg), 32'd0);
        end
      end
      if (bif.po_wea_inp) begin
        chk("cpwr_expected", 32'(cp_q.size() > 0), 32'd1);
        if (cp_q.size() > 0) begin
          c = cp_q.pop_front();
          d = fixed_mode ? 16'hA5A5 : regmem[c];
          chk("cpwr_a", 32'(bif.po_addra_inp), 32'(c));
          chk("cpwr_b", 32'(bif.po_addrb_inp), 32'(c + TOT));
          chk("cpwr_dia", 32'(bif.po_dia_inp), 32'(d));
          chk("cpwr_dib", 32'(bif.po_dib_inp), 32'(d));
          chk("cpwr_en", 32'({bif.po_ena_inp, bif.po_enb_inp, bif.po_web_inp}), 32'b111);
        end
      end
      busy_prev = bif.po_busy;
    end
  end

  function automatic logic any_out();
    return |{bif.po_busy, bif.po_done, bif.po_clc_accumulator, bif.po_valid,
             bif.po_accumulation_done, bif.po_ena_inp, bif.po_enb_inp, bif.po_wea_inp,
             bif.po_web_inp, bif.po_addra_inp, bif.po_addrb_inp, bif.po_dia_inp,
             bif.po_dib_inp, bif.po_ena_wei, bif.po_enb_wei, bif.po_addra_wei,
             bif.po_addrb_wei, bif.po_ena_reg, bif.po_enb_reg, bif.po_wea_reg,
             bif.po_web_reg, bif.po_addra_reg, bif.po_addrb_reg, cycle_cnt};
  endfunction

  task automatic run_pass(input int spur, input bit start_on_done);
    int t;
    build_model();
    @(posedge pi_clk); #1 bif.pi_start = 1'b1;
    @(posedge pi_clk); #1 bif.pi_start = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 500) begin
      @(posedge pi_clk); #1;
      t++;
      bif.pi_start = (t == spur) || (start_on_done && bif.po_done);
    end
    bif.pi_start = 1'b0;
    chk("done_seen", 32'(done_cnt), 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    chk("valid_pulses", 32'(valid_cnt), 32'(exp_valid));
    chk("mac_left", 32'(mac_q.size()), 32'd0);
    chk("regwr_left", 32'(wr_q.size()), 32'd0);
    chk("copy_left", 32'(cp_q.size()), 32'd0);
    chk("idle_after_done", 32'(bif.po_busy), 32'd0);
    @(posedge pi_clk); #1;
    chk("idle_next", 32'(bif.po_busy), 32'd0);
    chk("done_single", 32'(done_cnt), 32'd1);
`ifdef MLP_SEQ_PERF_CNT_EN
    chk("cycle_cnt", cycle_cnt, 32'(exp_busy));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    pi_rst_n = 1'b0; bif.pi_start = 1'b0; fixed_mode = 1'b0; busy_prev = 1'b0;
    repeat (2) @(posedge pi_clk);
    #1;
    chk("rst_outs_zero", 32'(any_out()), 32'd0);
    chk("rst_busy", 32'(bif.po_busy), 32'd0);
    #2 pi_rst_n = 1'b1;
    repeat (3) @(posedge pi_clk);
    #1 chk("idle_outs_zero", 32'(any_out()), 32'd0);

    // random BRAM contents, no extra start
    run_pass(0, 1'b0);
    // constant read data, start re-asserted mid-pass, start held during DONE
    fixed_mode = 1'b1;
    run_pass(10, 1'b1);

    // reset mid-pass
    fixed_mode = 1'b0;
    build_model();
    @(posedge pi_clk); #1 bif.pi_start = 1'b1;
    @(posedge pi_clk); #1 bif.pi_start = 1'b0;
    t = 0;
    while (busy_cnt < 20 && t < 200) begin @(posedge pi_clk); #1; t++; end
    chk("pre_abort_busy", 32'(bif.po_busy), 32'd1);
    #2 pi_rst_n = 1'b0;
    #1 chk("abort_outs_zero", 32'(any_out()), 32'd0);
    repeat (2) @(posedge pi_clk);
    #1 chk("abort_hold_zero", 32'(any_out()), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    pi_rst_n = 1'b1;
    run_pass(0, 1'b0);

    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(0, 5)) @(posedge pi_clk);
      fixed_mode = 1'($urandom_range(0, 1));
      run_pass(int'($urandom_range(2, 48)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
